disc_loop: RTL and testbench

DISC_LOOP -- requirements
Module: disc_loop

---
 rtl/disc_pkg.sv | 25 ++
 rtl/pps_phase_det.sv | 86 ++++++++
 rtl/disc_loop.sv | 98 +++++++++
 tb/tb_disc_loop.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disc_pkg.sv
// Shared types and widths for the 1 PPS disciplining loop.
// Holds the controller state encoding plus the DAC clamp used by the loop filter.
package disc_pkg;

  localparam int ERR_W = 28;
  localparam int INT_W = 32;
  localparam int SUM_W = 34;
  localparam logic [15:0] DAC_MID = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    ARM_TSC,
    ARM_GPS,
    CALC_I,
    CALC_S,
    LOAD
  } disc_state_t;

  function automatic logic [15:0] clamp_dac(input logic signed [SUM_W-1:0] v);
    if (v < 0) return 16'h0000;
    if (v > SUM_W'(65535)) return 16'hFFFF;
    return v[15:0];
  endfunction

endpackage

// File: rtl/pps_phase_det.sv
// Pairs local and reference 1 PPS pulses and measures their offset in clk cycles.
// Also sequences the fixed-latency filter stages so pulses are ignored while they run.
module pps_phase_det
  import disc_pkg::*;
#(
  parameter int WIN_MAX = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tsc_1pps,
  input  logic                    gps_1pps,
  output disc_state_t             state,
  output logic signed [ERR_W-1:0] err,
  output logic                    err_stb,
  output logic                    miss_stb
);

  disc_state_t             state_d;
  logic [ERR_W-1:0]        cnt, cnt_d;
  logic signed [ERR_W-1:0] err_d;
  logic                    err_stb_d, miss_d;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    err_d     = err;
    err_stb_d = 1'b0;
    miss_d    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (tsc_1pps && gps_1pps) begin
          err_d     = '0;
          err_stb_d = 1'b1;
          state_d   = CALC_I;
        end else if (tsc_1pps) begin
          cnt_d   = ERR_W'(1);
          state_d = ARM_TSC;
        end else if (gps_1pps) begin
          cnt_d   = ERR_W'(1);
          state_d = ARM_GPS;
        end
      end
      ARM_TSC, ARM_GPS: begin
        // A closing pulse wins even in the cycle the window expires.
        if ((state == ARM_TSC && gps_1pps) || (state == ARM_GPS && tsc_1pps)) begin
          err_d     = (state == ARM_TSC) ? -$signed(cnt) : $signed(cnt);
          err_stb_d = 1'b1;
          cnt_d     = '0;
          state_d   = CALC_I;
        end else if ((state == ARM_TSC && tsc_1pps) || (state == ARM_GPS && gps_1pps)) begin
          cnt_d = ERR_W'(1);
        end else if (cnt == ERR_W'(WIN_MAX)) begin
          miss_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + ERR_W'(1);
        end
      end
      CALC_I:  state_d = CALC_S;
      CALC_S:  state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      err      <= '0;
      err_stb  <= 1'b0;
      miss_stb <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      err      <= err_d;
      err_stb  <= err_stb_d;
      miss_stb <= miss_d;
    end
  end

endmodule

// File: rtl/disc_loop.sv
// 1 PPS disciplining loop: phase detector feeding a shift-gain PI filter that drives
// a 16-bit oscillator DAC, plus a consecutive-measurement lock qualifier.
module disc_loop
  import disc_pkg::*;
#(
  parameter int WIN_MAX  = 50_000_000,
  parameter int LOCK_TOL = 10,
  parameter int LOCK_CNT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tsc_1pps,
  input  logic                    gps_1pps,
  input  logic                    loop_ena,
  input  logic [3:0]              kp_shift,
  input  logic [3:0]              ki_shift,
  input  logic [15:0]             dac_init,
  output logic [15:0]             dac_val,
  output logic                    dac_ena,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    pps_miss,
  output logic                    locked
);

  localparam int IW1 = INT_W + 1;
  localparam int LCW = $clog2(LOCK_CNT + 1);

  disc_state_t             state;
  logic signed [ERR_W-1:0] err;
  logic                    err_stb, miss_stb;
  logic signed [INT_W-1:0] integ, integ_sat;
  logic signed [IW1-1:0]   integ_wide;
  logic signed [SUM_W-1:0] sum, sum_d, prop;
  logic [ERR_W-1:0]        err_mag;
  logic                    in_tol;
  logic [LCW-1:0]          lock_q;

  pps_phase_det #(.WIN_MAX(WIN_MAX)) u_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .tsc_1pps (tsc_1pps),
    .gps_1pps (gps_1pps),
    .state    (state),
    .err      (err),
    .err_stb  (err_stb),
    .miss_stb (miss_stb)
  );

  assign phase_err = err;
  assign pps_miss  = miss_stb;
  assign locked    = (lock_q == LCW'(LOCK_CNT));

  always_comb begin
    // Overflow shows up as the two top bits of the widened sum disagreeing.
    integ_wide = IW1'(integ) + IW1'(err >>> ki_shift);
    if (integ_wide[INT_W] != integ_wide[INT_W-1])
      integ_sat = integ_wide[INT_W] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    else
      integ_sat = integ_wide[INT_W-1:0];
    prop    = SUM_W'(err >>> kp_shift);
    sum_d   = SUM_W'($signed({1'b0, dac_init})) + prop + SUM_W'(integ);
    err_mag = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);
    in_tol  = (err_mag <= ERR_W'(LOCK_TOL));
  end

  // NOTE: every register, including the integrator and sum, has a defined reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ     <= '0;
      sum       <= '0;
      dac_val   <= DAC_MID;
      err_valid <= 1'b0;
      dac_ena   <= 1'b0;
    end else begin
      dac_ena   <= 1'b1;
      err_valid <= (state == LOAD);
      if (!loop_ena)    integ <= '0;
      else if (err_stb) integ <= integ_sat;
      if (state == CALC_S) sum <= sum_d;
      if (!loop_ena)            dac_val <= dac_init;
      else if (state == LOAD)   dac_val <= clamp_dac(sum);
    end
  end

  // Lock qualifier is evaluated in LOAD so locked moves in the same cycle as err_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
    end else if (!loop_ena || miss_stb) begin
      lock_q <= '0;
    end else if (state == LOAD) begin
      if (!in_tol)                         lock_q <= '0;
      else if (lock_q != LCW'(LOCK_CNT))   lock_q <= lock_q + LCW'(1);
    end
  end

endmodule

// File: tb/tb_disc_loop.sv
// Randomized scoreboard bench for disc_loop: stimulus pushes expected events from a
// behavioural model, a negedge monitor pops and compares on err_valid / pps_miss.
module tb_disc_loop;
  import disc_pkg::*;

  localparam int WIN_MAX  = 1000;
  localparam int LOCK_TOL = 10;
  localparam int LOCK_CNT = 8;

  logic clk = 1'b0, rst_n = 1'b1;
  logic tsc_1pps = 1'b0, gps_1pps = 1'b0, loop_ena = 1'b1;
  logic [3:0]  kp_shift = 4'd2, ki_shift = 4'd4;
  logic [15:0] dac_init = 16'h8000;
  logic [15:0] dac_val;
  logic        dac_ena, err_valid, pps_miss, locked;
  logic signed [ERR_W-1:0] phase_err;

  disc_loop #(.WIN_MAX(WIN_MAX), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .tsc_1pps(tsc_1pps), .gps_1pps(gps_1pps),
    .loop_ena(loop_ena), .kp_shift(kp_shift), .ki_shift(ki_shift), .dac_init(dac_init),
    .dac_val(dac_val), .dac_ena(dac_ena), .phase_err(phase_err), .err_valid(err_valid),
    .pps_miss(pps_miss), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit     miss;
    int     at;
    longint err;
    int     dac;
    bit     lck;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t got;
  int n_chk = 0, n_fail = 0;
  bit open_chk = 1'b0;

  // Reference model state: integrator, consecutive-good count, last error, last DAC code.
  longint m_integ = 0, m_err = 0;
  int     m_lock = 0, m_dac = 16'h8000;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint floor_div_pow2(input longint v, input int k);
    longint p = longint'(1) << k;
    return (v >= 0) ? v / p : -((-v + p - 1) / p);
  endfunction

  task automatic model_meas(input longint d, input int n);
    longint s;
    if (loop_ena) begin
      m_integ = m_integ + floor_div_pow2(d, int'(ki_shift));
      if (m_integ > 64'sd2147483647)  m_integ = 64'sd2147483647;
      if (m_integ < -64'sd2147483648) m_integ = -64'sd2147483648;
      s = longint'(dac_init) + floor_div_pow2(d, int'(kp_shift)) + m_integ;
      m_dac  = (s < 0) ? 0 : (s > 65535) ? 65535 : int'(s);
      m_lock = ((d <= LOCK_TOL) && (d >= -LOCK_TOL)) ? ((m_lock < LOCK_CNT) ? m_lock + 1 : m_lock) : 0;
    end else begin
      m_dac  = int'(dac_init);
      m_lock = 0;
    end
    m_err = d;
    sb.push_back('{miss: 1'b0, at: n + 4, err: d, dac: m_dac, lck: (m_lock == LOCK_CNT)});
  endtask

  always @(negedge clk) begin
    if (rst_n && (err_valid || pps_miss)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", 64'(err_valid) + 2 * 64'(pps_miss), 0);
      end else begin
        got = sb.pop_front();
        check("event_kind_miss", pps_miss, got.miss);
        check("event_cycle", cyc, got.at);
        check("phase_err", phase_err, got.err);
        check("dac_val", dac_val, got.dac);
        if (!got.miss) check("locked", locked, got.lck);
      end
    end
    if (rst_n && open_chk) begin
      check("open_loop_dac", dac_val, dac_init);
      check("open_loop_locked", locked, 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_first(input int d);
    if (d > 0) gps_1pps = 1'b1; else tsc_1pps = 1'b1;
  endtask

  // d = t(tsc) - t(gps); rpt re-fires the opening pulse rpt cycles in; xk fires a
  // stray pulse pair xk cycles after the closing pulse (1..3 land in the filter stages).
  task automatic meas(input int d, input int rpt, input int xk);
    int ad, n;
    ad = (d < 0) ? -d : d;
    tick();
    if (d == 0) begin
      tsc_1pps = 1'b1; gps_1pps = 1'b1;
    end else begin
      drive_first(d);
      if (rpt > 0) begin
        for (int i = 0; i < rpt; i++) begin tick(); tsc_1pps = 1'b0; gps_1pps = 1'b0; end
        drive_first(d);
      end
      for (int i = 0; i < ad; i++) begin tick(); tsc_1pps = 1'b0; gps_1pps = 1'b0; end
      if (d > 0) tsc_1pps = 1'b1; else gps_1pps = 1'b1;
    end
    n = cyc;
    model_meas(d, n);
    tick();
    tsc_1pps = 1'b0; gps_1pps = 1'b0;
    if (xk > 0) begin
      for (int i = 1; i < xk; i++) tick();
      tsc_1pps = 1'b1; gps_1pps = 1'b1;
      tick();
      tsc_1pps = 1'b0; gps_1pps = 1'b0;
    end
    while (cyc < n + 7) tick();
  endtask

  task automatic set_loop(input bit v);
    if (v && !loop_ena) m_dac = int'(dac_init);
    if (!v) begin m_integ = 0; m_lock = 0; end
    loop_ena = v;
    tick(); tick();
  endtask

  task automatic miss_tsc();
    int n;
    tick();
    tsc_1pps = 1'b1;
    n = cyc;
    sb.push_back('{miss: 1'b1, at: n + WIN_MAX + 1, err: m_err,
                   dac: (loop_ena ? m_dac : int'(dac_init)), lck: 1'b0});
    tick();
    tsc_1pps = 1'b0;
    repeat (WIN_MAX + 5) tick();
    m_lock = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dac_val"}, dac_val, 16'h8000);
    check({tag, "_dac_ena"}, dac_ena, 0);
    check({tag, "_phase_err"}, phase_err, 0);
    check({tag, "_err_valid"}, err_valid, 0);
    check({tag, "_pps_miss"}, pps_miss, 0);
    check({tag, "_locked"}, locked, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick();
    check("dac_ena_out_of_reset", dac_ena, 1);

    // Closed loop from reset: simultaneous pulses, then gps 100 cycles after tsc.
    meas(0, 0, 0);
    meas(-100, 0, 0);

    // Open loop: DAC tracks dac_init, measurement still reported.
    set_loop(1'b0);
    dac_init = 16'h1234;
    tick(); tick();
    open_chk = 1'b1;
    meas(50, 0, 0);
    meas(-50, 0, 2);
    open_chk = 1'b0;

    // Clamp at both DAC rails.
    dac_init = 16'hFFF0; kp_shift = 4'd0; ki_shift = 4'd15;
    tick(); tick();
    set_loop(1'b1);
    meas(1000, 0, 0);
    dac_init = 16'h0010;
    meas(-1000, 0, 0);

    // Repeated opening pulse restarts the count; stray pulses in the filter stages ignored.
    dac_init = 16'h8000; kp_shift = 4'd4; ki_shift = 4'd8;
    meas(-40, 30, 1);
    meas(35, 20, 3);

    // Lock up, unlock on a large error, relock, then lose it on a missed pulse.
    for (int i = 0; i < 8; i++) meas(3, 0, 0);
    check("locked_after_8", locked, 1);
    meas(20, 0, 0);
    check("unlocked_after_20", locked, 0);
    for (int i = 0; i < 8; i++) meas(-2, 0, 0);
    miss_tsc();
    check("miss_clears_lock", locked, 0);

    // Reset in the middle of an armed measurement, then a fresh opposite-order pair.
    tick();
    tsc_1pps = 1'b1;
    tick();
    tsc_1pps = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #1 check_reset_values("mid_arm_reset");
    tick();
    rst_n = 1'b1;
    m_integ = 0; m_lock = 0; m_err = 0; m_dac = 16'h8000;
    tick();
    meas(25, 0, 0);

    // Randomized pairs, gains, centre codes and loop mode.
    for (int it = 0; it < 40; it++) begin
      int d, rpt, xk;
      kp_shift = 4'($urandom_range(0, 15));
      ki_shift = 4'($urandom_range(0, 15));
      dac_init = 16'($urandom);
      tick(); tick();
      if ($urandom_range(0, 4) == 0) set_loop(!loop_ena);
      d   = int'($urandom_range(0, 600)) - 300;
      rpt = (d != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : 0;
      xk  = int'($urandom_range(0, 3));
      meas(d, rpt, xk);
    end
    set_loop(1'b1);
    miss_tsc();

    repeat (10) tick();
    check("pending_events", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
